// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C master engine between NUM_REQ requesters.
// Runs one transaction at a time with start-miss and overall timeout protection.
module i2c_bus_arbiter #(
    parameter int          NUM_REQ = 8,
    parameter logic [19:0] TIMEOUT = 20'd100000,
    parameter int          TO_W    = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [7*NUM_REQ-1:0] req_addr,
    input  logic [NUM_REQ-1:0]   req_rw,
    input  logic [NUM_REQ-1:0]   req_two_bytes,
    input  logic [16*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   done,
    output logic [15:0]          rsp_data,
    output logic                 rsp_err,
    output logic                 eng_start,
    output logic [6:0]           eng_addr,
    output logic                 eng_rw,
    output logic                 eng_two_bytes,
    output logic [15:0]          eng_data,
    output logic                 eng_abort,
    input  logic [15:0]          eng_read_data,
    input  logic                 eng_ready
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, ABORT, RESP} state_t;

    state_t          state, state_nxt;
    logic [TO_W-1:0] timer, timer_inc;
    logic [IW-1:0]   last, idx, pick_idx;
    logic            pick_found;
    logic            time_up;
    logic [6:0]      lat_addr;
    logic            lat_rw, lat_two;
    logic [15:0]     lat_data;

    // Search from last+1 upward with wrap; the lowest offset wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req_valid[(int'(last) + k) % NUM_REQ]) begin
                pick_found = 1'b1;
                pick_idx   = IW'((int'(last) + k) % NUM_REQ);
            end
        end
    end

    assign timer_inc = (&timer) ? timer : timer + 1'b1;
    // Timeout is judged on the value the timer is about to take, so it beats a same-cycle ready.
    assign time_up   = (timer_inc == TO_W'(TIMEOUT - 20'd1));

    always_comb begin
        state_nxt = state;
        grant     = '0;
        done      = '0;
        eng_start = 1'b0;
        eng_abort = 1'b0;
        case (state)
            IDLE: begin
                if (eng_ready && pick_found) state_nxt = ISSUE;
            end
            ISSUE: begin
                grant[idx] = 1'b1;
                eng_start  = 1'b1;
                state_nxt  = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (time_up)                      state_nxt = ABORT;
                else if (!eng_ready)              state_nxt = WAIT_DONE;
                else if (timer == TO_W'(3))       state_nxt = ABORT;
            end
            WAIT_DONE: begin
                if (time_up)        state_nxt = ABORT;
                else if (eng_ready) state_nxt = RESP;
            end
            ABORT: begin
                eng_abort = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                done[idx] = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            timer    <= '0;
            last     <= IW'(NUM_REQ - 1);
            idx      <= '0;
            lat_addr <= '0;
            lat_rw   <= 1'b0;
            lat_two  <= 1'b0;
            lat_data <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (state_nxt == ISSUE) begin
                        idx      <= pick_idx;
                        lat_addr <= req_addr[7*int'(pick_idx) +: 7];
                        lat_rw   <= req_rw[pick_idx];
                        lat_two  <= req_two_bytes[pick_idx];
                        lat_data <= req_rw[pick_idx] ? 16'd0 : req_wdata[16*int'(pick_idx) +: 16];
                    end
                end
                ISSUE: timer <= '0;
                WAIT_BUSY, WAIT_DONE: begin
                    timer <= timer_inc;
                    if (state_nxt == ABORT) begin
                        rsp_data <= 16'd0;
                        rsp_err  <= 1'b1;
                    end else if (state_nxt == RESP) begin
                        rsp_data <= lat_rw ? eng_read_data : 16'd0;
                        rsp_err  <= 1'b0;
                    end
                end
                RESP: last <= idx;
                default: ;
            endcase
        end
    end

    assign eng_addr      = lat_addr;
    assign eng_rw        = lat_rw;
    assign eng_two_bytes = lat_two;
    assign eng_data      = lat_data;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter: vector table for round-robin order plus
// hand-written sequences for timeout, missed start and mid-transaction reset.
module tb_i2c_bus_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   req_valid;
    logic [55:0]  req_addr;
    logic [7:0]   req_rw;
    logic [7:0]   req_two_bytes;
    logic [127:0] req_wdata;
    logic [7:0]   grant, done;
    logic [15:0]  rsp_data;
    logic         rsp_err;
    logic         eng_start;
    logic [6:0]   eng_addr;
    logic         eng_rw, eng_two_bytes;
    logic [15:0]  eng_data;
    logic         eng_abort;
    logic [15:0]  eng_read_data;
    logic         eng_ready;

    i2c_bus_arbiter #(.NUM_REQ(8), .TIMEOUT(20'd100), .TO_W(20)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_rw(req_rw), .req_two_bytes(req_two_bytes), .req_wdata(req_wdata),
        .grant(grant), .done(done), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .eng_start(eng_start), .eng_addr(eng_addr), .eng_rw(eng_rw),
        .eng_two_bytes(eng_two_bytes), .eng_data(eng_data), .eng_abort(eng_abort),
        .eng_read_data(eng_read_data), .eng_ready(eng_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  req;
        int          dr;
        int          rs;
        logic [15:0] rd;
        logic [7:0]  exp_g;
        logic [15:0] exp_rsp;
    } vec_t;

    vec_t vecs[16];

    logic [7:0] rw_mask = 8'b1010_0110;
    logic [7:0] tb_mask = 8'b0011_0101;

    int n_chk = 0, n_pass = 0;
    int cyc = 0, t0, g_cyc, a_cyc, d_cyc;
    logic [7:0]  g_val, d_val;
    logic [6:0]  g_addr;
    logic        g_rw, g_two, g_start, d_err;
    logic [15:0] g_data, d_rsp;
    int          drop_at = 1000, rise_at = 1000, e_k = 0;
    logic        e_act = 1'b0, hold_low = 1'b0;
    logic [15:0] rdata = 16'h0;

    function automatic logic [6:0] addr_of(int i);
        return 7'h48 + 7'(i);
    endfunction
    function automatic logic [15:0] wd_of(int i);
        return 16'hC0C0 + 16'(i) * 16'h0101;
    endfunction
    function automatic int idx_of(logic [7:0] oh);
        for (int i = 0; i < 8; i++) if (oh[i]) return i;
        return 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // One clock: sample after the edge, then play the engine for the new cycle.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (rst || eng_abort) e_act = 1'b0;
        else if (eng_start) begin e_act = 1'b1; e_k = 0; end
        else if (e_act) e_k++;
        if (done != 0) e_act = 1'b0;
        if (hold_low) eng_ready = 1'b0;
        else if (e_act && e_k >= drop_at && e_k < rise_at) eng_ready = 1'b0;
        else eng_ready = 1'b1;
        eng_read_data = rdata;
        if (grant != 0 || done != 0)
            chk($sformatf("onehot c%0d", cyc),
                {29'd0, $onehot0(grant), $onehot0(done), !(grant != 0 && done != 0)}, 32'd7);
    endtask

    task automatic run_txn(input logic [7:0] rq, input int dr, input int rs, input logic [15:0] rd);
        req_valid = rq; drop_at = dr; rise_at = rs; rdata = rd;
        t0 = cyc; g_cyc = -1; a_cyc = -1; d_cyc = -1; g_val = '0; d_val = '0;
        for (int n = 0; n < 400 && d_cyc < 0; n++) begin
            step();
            if (grant != 0 && g_cyc < 0) begin
                g_cyc = cyc; g_val = grant; g_addr = eng_addr; g_rw = eng_rw;
                g_two = eng_two_bytes; g_data = eng_data; g_start = eng_start;
            end
            if (eng_abort && a_cyc < 0) a_cyc = cyc;
            if (done != 0) begin d_cyc = cyc; d_val = done; d_rsp = rsp_data; d_err = rsp_err; end
        end
        if (d_cyc < 0) chk("txn finished", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: no finish by %0t", $time);
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{8'hFF, 1, 2, 16'h1111, 8'h01, 16'h0000};
        vecs[1]  = '{8'hFE, 2, 5, 16'h2222, 8'h02, 16'h2222};
        vecs[2]  = '{8'hFC, 1, 3, 16'h3333, 8'h04, 16'h3333};
        vecs[3]  = '{8'hF8, 2, 4, 16'h4444, 8'h08, 16'h0000};
        vecs[4]  = '{8'hF0, 1, 6, 16'h5555, 8'h10, 16'h0000};
        vecs[5]  = '{8'hE0, 1, 2, 16'h6666, 8'h20, 16'h6666};
        vecs[6]  = '{8'hC0, 2, 3, 16'h7777, 8'h40, 16'h0000};
        vecs[7]  = '{8'h80, 1, 4, 16'h8888, 8'h80, 16'h8888};
        vecs[8]  = '{8'hFF, 1, 2, 16'h9999, 8'h01, 16'h0000};
        vecs[9]  = '{8'h22, 1, 3, 16'hAAAA, 8'h02, 16'hAAAA};
        vecs[10] = '{8'h22, 2, 4, 16'hBBBB, 8'h20, 16'hBBBB};
        vecs[11] = '{8'h22, 1, 2, 16'hCCCC, 8'h02, 16'hCCCC};
        vecs[12] = '{8'h22, 1, 5, 16'hDDDD, 8'h20, 16'hDDDD};
        vecs[13] = '{8'h2A, 1, 2, 16'h1357, 8'h02, 16'h1357};
        vecs[14] = '{8'h2A, 2, 3, 16'h2468, 8'h08, 16'h0000};
        vecs[15] = '{8'h2A, 1, 2, 16'h0F0F, 8'h20, 16'h0F0F};

        rst = 1'b1; req_valid = '0; eng_ready = 1'b1; eng_read_data = '0;
        for (int i = 0; i < 8; i++) begin
            req_addr[7*i +: 7]   = addr_of(i);
            req_rw[i]            = rw_mask[i];
            req_two_bytes[i]     = tb_mask[i];
            req_wdata[16*i +: 16] = wd_of(i);
        end
        do_reset();
        chk("reset grant/done/flags", {13'd0, grant, done, eng_start, eng_abort, rsp_err}, 32'd0);
        chk("reset rsp_data", rsp_data, 32'd0);
        chk("reset eng fields", {eng_addr, eng_rw, eng_two_bytes, eng_data}, 32'd0);

        // Single read request from requester 2
        run_txn(8'h04, 2, 40, 16'h1980);
        chk("single grant latency", g_cyc - t0, 32'd1);
        chk("single grant", g_val, 32'h04);
        chk("single eng_start", g_start, 32'd1);
        chk("single eng_addr", g_addr, 32'h4A);
        chk("single eng_rw/two", {g_rw, g_two}, 32'd3);
        chk("single eng_data", g_data, 32'd0);
        chk("single done", d_val, 32'h04);
        chk("single rsp_data", d_rsp, 32'h1980);
        chk("single rsp_err", d_err, 32'd0);
        chk("single done latency", d_cyc - g_cyc, 32'd41);
        req_valid = '0;
        do_reset();

        for (int i = 0; i < 16; i++) begin
            int gi;
            run_txn(vecs[i].req, vecs[i].dr, vecs[i].rs, vecs[i].rd);
            gi = idx_of(vecs[i].exp_g);
            chk($sformatf("v%0d grant", i), g_val, vecs[i].exp_g);
            chk($sformatf("v%0d eng_addr", i), g_addr, addr_of(gi));
            chk($sformatf("v%0d eng_rw/two", i), {g_rw, g_two}, {30'd0, rw_mask[gi], tb_mask[gi]});
            chk($sformatf("v%0d eng_data", i), g_data, rw_mask[gi] ? 16'd0 : wd_of(gi));
            chk($sformatf("v%0d done", i), d_val, vecs[i].exp_g);
            chk($sformatf("v%0d rsp", i), {d_err, d_rsp}, {15'd0, 1'b0, vecs[i].exp_rsp});
            chk($sformatf("v%0d no abort", i), a_cyc, 32'hFFFF_FFFF);
            chk($sformatf("v%0d latency", i), d_cyc - g_cyc, vecs[i].rs + 1);
        end

        // Engine never comes back: abort 100 cycles after start
        run_txn(8'h01, 1, 1000, 16'h1234);
        chk("to grant", g_val, 32'h01);
        chk("to abort cycle", a_cyc - g_cyc, 32'd100);
        chk("to done cycle", d_cyc - g_cyc, 32'd101);
        chk("to done", d_val, 32'h01);
        chk("to rsp", {d_err, d_rsp}, 32'h1_0000);

        // Ready rising on the timeout cycle still aborts
        run_txn(8'h02, 1, 99, 16'hFFFF);
        chk("to99 abort cycle", a_cyc - g_cyc, 32'd100);
        chk("to99 rsp", {d_err, d_rsp}, 32'h1_0000);

        // One cycle earlier completes normally
        run_txn(8'h04, 1, 98, 16'h0BAD);
        chk("to98 no abort", a_cyc, 32'hFFFF_FFFF);
        chk("to98 done cycle", d_cyc - g_cyc, 32'd99);
        chk("to98 rsp", {d_err, d_rsp}, 32'h0_0BAD);

        // Engine takes the start on the last allowed cycle
        run_txn(8'h20, 4, 6, 16'h7E57);
        chk("late busy no abort", a_cyc, 32'hFFFF_FFFF);
        chk("late busy done cycle", d_cyc - g_cyc, 32'd7);
        chk("late busy rsp", {d_err, d_rsp}, 32'h0_7E57);

        // Engine never leaves ready: missed start
        run_txn(8'h80, 1000, 1000, 16'h4321);
        chk("miss grant", g_val, 32'h80);
        chk("miss abort cycle", a_cyc - g_cyc, 32'd5);
        chk("miss done", {d_val, 24'd0} | 32'(d_cyc - g_cyc), 32'h8000_0006);
        chk("miss rsp", {d_err, d_rsp}, 32'h1_0000);

        // Reset while waiting for the engine to finish
        begin
            int gc, bad;
            req_valid = 8'h02; drop_at = 1; rise_at = 1000; rdata = 16'h0;
            gc = -1;
            for (int n = 0; n < 20 && gc < 0; n++) begin
                step();
                if (grant != 0) gc = cyc;
            end
            chk("rstmid first grant", grant, 32'h02);
            repeat (10) step();
            chk("rstmid err held", rsp_err, 32'd1);
            rst = 1'b1; hold_low = 1'b1;
            step();
            rst = 1'b0;
            chk("rstmid grant/done/flags", {13'd0, grant, done, eng_start, eng_abort, rsp_err}, 32'd0);
            chk("rstmid rsp_data", rsp_data, 32'd0);
            chk("rstmid eng fields", {eng_addr, eng_rw, eng_two_bytes, eng_data}, 32'd0);
            bad = 0;
            repeat (6) begin
                step();
                if (grant != 0 || done != 0 || eng_start || eng_abort) bad++;
            end
            chk("rstmid quiet while not ready", bad, 32'd0);
            hold_low = 1'b0; drop_at = 1; rise_at = 5; rdata = 16'h5A5A; eng_ready = 1'b1;
            step();
            chk("rstmid regrant", grant, 32'h02);
            d_cyc = -1; d_val = '0;
            for (int n = 0; n < 50 && d_cyc < 0; n++) begin
                step();
                if (done != 0) begin d_cyc = cyc; d_val = done; d_rsp = rsp_data; d_err = rsp_err; end
            end
            chk("rstmid done", d_val, 32'h02);
            chk("rstmid rsp", {d_err, d_rsp}, 32'h0_5A5A);
            req_valid = '0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
- Shares one I2C master engine between NUM_REQ requesters, for example the temperature and light-sensor readers on the same SDA/SCL pair.
- Arbitrates round-robin and runs exactly one transaction at a time.
- Forwards the winner's addr/rw/two_bytes/data to the engine and returns read data, a done pulse and a timeout error to the winner.
- Sits between the sensor sequencers and the single engine.

Parameters:
- NUM_REQ, 8: number of requesters.
- TIMEOUT, 20'd100000: maximum cycles from engine start to engine ready before abort.
- TO_W, 20: timer width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester request level; held until grant
- req_addr  in  7*NUM_REQ  slave address; requester i in bits [7i+6:7i]
- req_rw  in  NUM_REQ  0=write, 1=read
- req_two_bytes  in  NUM_REQ  1=two data bytes, 0=one
- req_wdata  in  16*NUM_REQ  write data; requester i in bits [16i+15:16i]
- grant  out  NUM_REQ  one-hot, one-cycle pulse: request accepted
- done  out  NUM_REQ  one-hot, one-cycle pulse: transaction finished
- rsp_data  out  16  read data, valid while any done bit is high
- rsp_err  out  1  timeout flag, valid while any done bit is high
- eng_start  out  1  one-cycle start to the engine
- eng_addr  out  7  to engine
- eng_rw  out  1  to engine
- eng_two_bytes  out  1  to engine
- eng_data  out  16  to engine
- eng_abort  out  1  one-cycle engine reset on timeout
- eng_read_data  in  16  from engine
- eng_ready  in  1  engine idle/complete

Behaviour:
- Reset applies on the clk edge while rst=1. Reset values:
  - All outputs 0.
  - State IDLE, timer 0.
  - Round-robin pointer last = NUM_REQ-1, so requester 0 has top priority first.
  - Latched fields 0.
- Reset mid-transaction drops the transaction silently: no done, no abort. The engine is reset by the same rst.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, ABORT, RESP.
- IDLE:
  - If eng_ready=1 and |req_valid, pick the first set bit searching from (last+1) mod NUM_REQ upward with wrap.
  - Latch its index, addr, rw, two_bytes and wdata (wdata forced to 0 when rw=1). Go to ISSUE.
  - If eng_ready=0, stay in IDLE whatever the requests.
- ISSUE (exactly 1 cycle):
  - grant[idx]=1, eng_start=1, timer cleared. Go to WAIT_BUSY.
  - eng_addr/eng_rw/eng_two_bytes/eng_data drive the latched values from ISSUE through RESP and hold them otherwise.
- WAIT_BUSY:
  - Wait for eng_ready=0 (engine took the start), then go to WAIT_DONE.
  - If eng_ready stays 1 for 4 cycles, the engine missed the start: go to ABORT.
- WAIT_DONE:
  - On eng_ready=1, capture rsp_data = rw ? eng_read_data : 16'd0, set rsp_err=0, go to RESP.
- Timer:
  - Increments every cycle in WAIT_BUSY and WAIT_DONE and saturates.
  - Reaching TIMEOUT-1 in either state means go to ABORT, even if eng_ready rises in that same cycle (timeout wins).
- ABORT (1 cycle): eng_abort=1, rsp_data=0, rsp_err=1. Go to RESP.
- RESP (1 cycle):
  - done[idx]=1; rsp_data and rsp_err valid.
  - last <= idx. Go to IDLE.
  - In the following IDLE cycle rsp_data/rsp_err hold their values; done is 0.
- Latency: a request sampled in IDLE with eng_ready=1 gives grant and eng_start on the next cycle. A zero-delay engine therefore gives done no sooner than 4 cycles after the request.
- req_valid is ignored outside IDLE. A requester deasserting before its grant is simply not picked. One still asserted after its done competes again, with lowest priority.
- grant and done are never both high. At most one grant bit and one done bit are high in any cycle.
- Requesters not granted see no response.

Test Plan:
- Single request: req_valid=8'b0000_0100, addr 7'h4A, rw=1, two_bytes=1; engine drops ready 2 cycles after start and returns 16'h1980 after 40 cycles -> grant=8'h04 one cycle after request; eng_addr=7'h4A, eng_rw=1, eng_data=0; done=8'h04 with rsp_data=16'h1980, rsp_err=0.
- All requests asserted (8'hFF) after reset, each requester dropping req_valid after its done -> grants in order 0,1,...,7. Re-asserting 8'hFF with last=7 -> next grant is 0.
- Fairness: requesters 1 and 5 held continuously -> grants alternate 1,5,1,5. Then add requester 3 while 5 is active -> order after 5 is 1,3,5.
- Timeout: TIMEOUT=20'd100, engine drops ready and never raises it -> eng_abort pulse at cycle 100 after start, done[idx]=1, rsp_err=1, rsp_data=0. Repeat with ready rising at exactly cycle 99 -> still error.
- Missed start: engine keeps eng_ready=1 after eng_start -> eng_abort after 4 cycles, rsp_err=1.
- Reset mid-transaction: rst for 1 cycle during WAIT_DONE -> next cycle all outputs 0, no done; engine held not-ready delays the next grant until eng_ready=1.
